// File: rtl/alu_pkg.sv
// alu_pkg: ALU mode codes, arbiter state type and the HI-writer helper
package alu_pkg;
  typedef logic [3:0] alu_mode_t;
  localparam alu_mode_t ALU_NOP  = 4'b0000;
  localparam alu_mode_t ALU_ADD  = 4'b0001;
  localparam alu_mode_t ALU_SUB  = 4'b0010;
  localparam alu_mode_t ALU_MUL  = 4'b0011;
  localparam alu_mode_t ALU_DIV  = 4'b0100;
  localparam alu_mode_t ALU_AND  = 4'b0101;
  localparam alu_mode_t ALU_OR   = 4'b0110;
  localparam alu_mode_t ALU_XOR  = 4'b0111;
  localparam alu_mode_t ALU_NOR  = 4'b1000;
  localparam alu_mode_t ALU_SLL  = 4'b1001;
  localparam alu_mode_t ALU_SLR  = 4'b1010;
  localparam alu_mode_t ALU_SLT  = 4'b1011;
  localparam alu_mode_t ALU_MFHI = 4'b1101;
  localparam alu_mode_t ALU_EQ   = 4'b1110;
  localparam alu_mode_t ALU_NEQ  = 4'b1111;
  typedef enum logic {ARB_FREE, ARB_LOCKED} arb_state_t;
  function automatic logic writes_hi(input alu_mode_t m);
    return m == ALU_MUL || m == ALU_DIV;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first eligible requester after ptr
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  input  logic [NREQ-1:0] mask_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);
  logic [NREQ-1:0] elig;
  assign elig = req_i & mask_i;
  // scan farthest-first so the nearest eligible requester overwrites the rest
  always_comb begin
    int j;
    j = 0;
    grant_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (elig[IW'(j)]) begin
        grant_o = NREQ'(1) << j;
        idx_o = IW'(j);
        any_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between NREQ requesters with round-robin
// arbitration, a registered response and an owner lock with idle timeout
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N = 32,
  parameter int NREQ = 2,
  parameter int LOCK_MAX = 8,
  localparam int IW = $clog2(NREQ),
  localparam int CW = $clog2(LOCK_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ*N-1:0] req_x_i,
  input  logic [NREQ*N-1:0] req_y_i,
  input  logic [NREQ*4-1:0] req_mode_i,
  input  logic [NREQ-1:0]   req_lock_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [N-1:0]      alu_x_o,
  output logic [N-1:0]      alu_y_o,
  output logic [3:0]        alu_mode_o,
  input  logic [N-1:0]      alu_z_i,
  output logic              rsp_valid_o,
  output logic [IW-1:0]     rsp_id_o,
  output logic [N-1:0]      rsp_z_o,
  output logic              locked_o,
  output logic              lock_timeout_o
);
  arb_state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, owner_q, owner_d, rsp_id_q, rsp_id_d, win;
  logic [CW-1:0] idle_q, idle_d;
  logic [N-1:0] rsp_z_q, rsp_z_d;
  logic rsp_valid_q, rsp_valid_d, timeout_q, timeout_d;
  logic [NREQ-1:0] mask, grant;
  logic any, accept, lock_sel, expire;
  assign mask = state_q == ARB_LOCKED ? NREQ'(1) << owner_q : '1;
  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i(req_valid_i),
    .ptr_i(ptr_q),
    .mask_i(mask),
    .grant_o(grant),
    .idx_o(win),
    .any_o(any)
  );
  // reset gates the grant combinationally so the ALU sees NOP while rst is high
  assign accept = any & ~rst;
  assign lock_sel = req_lock_i[win];
  assign expire = state_q == ARB_LOCKED && !accept && idle_q == CW'(LOCK_MAX - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_FREE;
      ptr_q <= IW'(NREQ - 1);
      owner_q <= '0;
      idle_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_z_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      idle_q <= idle_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_z_q <= rsp_z_d;
      timeout_q <= timeout_d;
    end
  end
  always_comb begin
    state_d = accept ? (lock_sel ? ARB_LOCKED : ARB_FREE) : (expire ? ARB_FREE : state_q);
    owner_d = accept ? win : owner_q;
    ptr_d = accept ? win : ptr_q;
    idle_d = (state_q == ARB_LOCKED && !accept && !expire) ? idle_q + 1'b1 : '0;
    rsp_valid_d = accept;
    rsp_id_d = accept ? win : rsp_id_q;
    rsp_z_d = accept ? alu_z_i : rsp_z_q;
    timeout_d = expire;
  end
  always_comb begin
    req_ready_o = rst ? '0 : grant;
    alu_x_o = accept ? req_x_i[int'(win)*N +: N] : '0;
    alu_y_o = accept ? req_y_i[int'(win)*N +: N] : '0;
    alu_mode_o = accept ? req_mode_i[int'(win)*4 +: 4] : ALU_NOP;
  end
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o = rsp_id_q;
  assign rsp_z_o = rsp_z_q;
  assign locked_o = state_q == ARB_LOCKED;
  assign lock_timeout_o = timeout_q;
  ap_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready_o));
  ap_hi_owner: assert property (@(posedge clk) disable iff (rst)
    accept && lock_sel && writes_hi(alu_mode_o) |=> !accept || win == $past(win));
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed table plus lock/timeout/reset/idle sequences against a behavioural ALU
module tb_alu_arbiter;
  import alu_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] v, lk, req_ready;
  logic [3:0] m0, m1, alu_mode;
  logic [31:0] x0, y0, x1, y1, alu_x, alu_y, alu_z, rsp_z;
  logic rsp_valid, locked, lock_timeout;
  logic [0:0] rsp_id;
  logic [31:0] hi_q = '0;
  logic [63:0] prod;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  alu_arbiter #(.N(32), .NREQ(2), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(v), .req_x_i({x1, x0}), .req_y_i({y1, y0}),
    .req_mode_i({m1, m0}), .req_lock_i(lk), .req_ready_o(req_ready),
    .alu_x_o(alu_x), .alu_y_o(alu_y), .alu_mode_o(alu_mode), .alu_z_i(alu_z),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_z_o(rsp_z),
    .locked_o(locked), .lock_timeout_o(lock_timeout)
  );
  assign prod = {32'b0, alu_x} * {32'b0, alu_y};
  always_comb begin
    alu_z = '0;
    case (alu_mode)
      ALU_ADD:  alu_z = alu_x + alu_y;
      ALU_SUB:  alu_z = alu_x - alu_y;
      ALU_MUL:  alu_z = prod[31:0];
      ALU_DIV:  alu_z = alu_y != 0 ? alu_x / alu_y : '0;
      ALU_AND:  alu_z = alu_x & alu_y;
      ALU_OR:   alu_z = alu_x | alu_y;
      ALU_XOR:  alu_z = alu_x ^ alu_y;
      ALU_MFHI: alu_z = hi_q;
      default:  alu_z = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (alu_mode == ALU_MUL) hi_q <= prod[63:32];
    else if (alu_mode == ALU_DIV && alu_y != 0) hi_q <= alu_x % alu_y;
  end
  typedef struct {
    logic [1:0] v, lk, rdy;
    logic [3:0] m0, m1, amode;
    logic [31:0] x0, y0, x1, y1, rz;
    logic rv, rid, lkd;
  } vec_t;
  vec_t tv[12];
  function automatic vec_t mk(input logic [1:0] v_, input logic [3:0] m0_, input logic [31:0] x0_, y0_,
                              input logic [3:0] m1_, input logic [31:0] x1_, y1_, input logic [1:0] lk_,
                              input logic [1:0] rdy_, input logic [3:0] am_, input logic rv_, rid_,
                              input logic [31:0] rz_, input logic lkd_);
    vec_t r;
    r.v = v_; r.m0 = m0_; r.x0 = x0_; r.y0 = y0_; r.m1 = m1_; r.x1 = x1_; r.y1 = y1_; r.lk = lk_;
    r.rdy = rdy_; r.amode = am_; r.rv = rv_; r.rid = rid_; r.rz = rz_; r.lkd = lkd_;
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [1:0] v_, input logic [3:0] m0_, input logic [31:0] x0_, y0_,
                       input logic [3:0] m1_, input logic [31:0] x1_, y1_, input logic [1:0] lk_);
    v = v_; m0 = m0_; x0 = x0_; y0 = y0_; m1 = m1_; x1 = x1_; y1 = y1_; lk = lk_;
  endtask
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tv[0]  = mk(2'b01, ALU_ADD, 32'h33333333, 32'h02222222, ALU_NOP, 0, 0, 2'b00, 2'b01, ALU_ADD, 0, 0, 0, 0);
    tv[1]  = mk(2'b00, ALU_NOP, 0, 0, ALU_NOP, 0, 0, 2'b00, 2'b00, ALU_NOP, 1, 0, 32'h35555555, 0);
    tv[2]  = mk(2'b10, ALU_NOP, 0, 0, ALU_ADD, 1, 2, 2'b00, 2'b10, ALU_ADD, 0, 0, 0, 0);
    tv[3]  = mk(2'b11, ALU_SUB, 10, 3, ALU_SUB, 32'h100, 1, 2'b00, 2'b01, ALU_SUB, 1, 1, 3, 0);
    tv[4]  = mk(2'b11, ALU_SUB, 10, 3, ALU_SUB, 32'h100, 1, 2'b00, 2'b10, ALU_SUB, 1, 0, 7, 0);
    tv[5]  = mk(2'b11, ALU_SUB, 10, 3, ALU_SUB, 32'h100, 1, 2'b00, 2'b01, ALU_SUB, 1, 1, 32'hFF, 0);
    tv[6]  = mk(2'b11, ALU_SUB, 10, 3, ALU_SUB, 32'h100, 1, 2'b00, 2'b10, ALU_SUB, 1, 0, 7, 0);
    tv[7]  = mk(2'b00, ALU_NOP, 0, 0, ALU_NOP, 0, 0, 2'b00, 2'b00, ALU_NOP, 1, 1, 32'hFF, 0);
    tv[8]  = mk(2'b11, ALU_MUL, 32'h33333333, 32'h02222222, ALU_ADD, 5, 6, 2'b01, 2'b01, ALU_MUL, 0, 0, 0, 0);
    tv[9]  = mk(2'b11, ALU_MFHI, 0, 0, ALU_ADD, 5, 6, 2'b00, 2'b01, ALU_MFHI, 1, 0, 32'hCC5F92C6, 1);
    tv[10] = mk(2'b11, ALU_MFHI, 0, 0, ALU_ADD, 5, 6, 2'b00, 2'b10, ALU_ADD, 1, 0, 32'h006D3A06, 0);
    tv[11] = mk(2'b00, ALU_NOP, 0, 0, ALU_NOP, 0, 0, 2'b00, 2'b00, ALU_NOP, 1, 1, 32'hB, 0);
    drive(2'b00, ALU_NOP, 0, 0, ALU_NOP, 0, 0, 2'b00);
    @(negedge clk);
    chk("reset ready", req_ready, 0);
    chk("reset alu_mode", alu_mode, ALU_NOP);
    chk("reset alu_x", alu_x, 0);
    chk("reset alu_y", alu_y, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_id", rsp_id, 0);
    chk("reset rsp_z", rsp_z, 0);
    chk("reset locked", locked, 0);
    chk("reset lock_timeout", lock_timeout, 0);
    rst = 1'b0;
    next_cycle();
    for (int i = 0; i < 12; i++) begin
      drive(tv[i].v, tv[i].m0, tv[i].x0, tv[i].y0, tv[i].m1, tv[i].x1, tv[i].y1, tv[i].lk);
      @(negedge clk);
      chk($sformatf("row%0d ready", i), req_ready, tv[i].rdy);
      chk($sformatf("row%0d alu_mode", i), alu_mode, tv[i].amode);
      chk($sformatf("row%0d rsp_valid", i), rsp_valid, tv[i].rv);
      chk($sformatf("row%0d locked", i), locked, tv[i].lkd);
      if (tv[i].rv) begin
        chk($sformatf("row%0d rsp_id", i), rsp_id, tv[i].rid);
        chk($sformatf("row%0d rsp_z", i), rsp_z, tv[i].rz);
      end
      next_cycle();
    end
    // lock timeout: owner goes quiet after a locked MUL
    drive(2'b11, ALU_MUL, 32'h10, 32'h20, ALU_ADD, 1, 1, 2'b01);
    @(negedge clk);
    chk("to grant mul", req_ready, 2'b01);
    next_cycle();
    drive(2'b10, ALU_NOP, 0, 0, ALU_ADD, 1, 1, 2'b00);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("to c%0d locked", c), locked, 1);
      chk($sformatf("to c%0d ready", c), req_ready, 0);
      chk($sformatf("to c%0d alu_mode", c), alu_mode, ALU_NOP);
      chk($sformatf("to c%0d pulse", c), lock_timeout, 0);
      if (c == 1) chk("to mul rsp_z", rsp_z, 32'h200);
      next_cycle();
    end
    @(negedge clk);
    chk("to released", locked, 0);
    chk("to pulse", lock_timeout, 1);
    chk("to req1 ready", req_ready, 2'b10);
    next_cycle();
    drive(2'b00, ALU_NOP, 0, 0, ALU_NOP, 0, 0, 2'b00);
    @(negedge clk);
    chk("to pulse end", lock_timeout, 0);
    chk("to rsp_id", rsp_id, 1);
    chk("to rsp_z", rsp_z, 2);
    next_cycle();
    // asynchronous reset while locked with a response pending
    drive(2'b01, ALU_MUL, 32'h10000, 32'h30000, ALU_NOP, 0, 0, 2'b01);
    @(negedge clk);
    chk("rst mul ready", req_ready, 2'b01);
    next_cycle();
    drive(2'b11, ALU_MFHI, 0, 0, ALU_ADD, 5, 6, 2'b00);
    @(negedge clk);
    chk("pre-rst rsp_valid", rsp_valid, 1);
    chk("pre-rst locked", locked, 1);
    chk("pre-rst alu_mode", alu_mode, ALU_MFHI);
    #1 rst = 1'b1;
    #1;
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst locked", locked, 0);
    chk("rst alu_mode", alu_mode, ALU_NOP);
    chk("rst ready", req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    drive(2'b11, ALU_ADD, 7, 8, ALU_ADD, 5, 6, 2'b00);
    rst = 1'b0;
    #1;
    chk("post-rst ready", req_ready, 2'b01);
    chk("post-rst alu_mode", alu_mode, ALU_ADD);
    next_cycle();
    drive(2'b00, ALU_NOP, 0, 0, ALU_NOP, 0, 0, 2'b00);
    @(negedge clk);
    chk("post-rst rsp_id", rsp_id, 0);
    chk("post-rst rsp_z", rsp_z, 32'hF);
    // idle stretch, then MFHI still sees HI of the last MUL
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("idle%0d alu_mode", c), alu_mode, ALU_NOP);
      chk($sformatf("idle%0d rsp_valid", c), rsp_valid, 0);
    end
    next_cycle();
    drive(2'b10, ALU_NOP, 0, 0, ALU_MFHI, 0, 0, 2'b00);
    @(negedge clk);
    chk("mfhi ready", req_ready, 2'b10);
    next_cycle();
    drive(2'b00, ALU_NOP, 0, 0, ALU_NOP, 0, 0, 2'b00);
    @(negedge clk);
    chk("mfhi rsp_valid", rsp_valid, 1);
    chk("mfhi rsp_id", rsp_id, 1);
    chk("mfhi rsp_z", rsp_z, 32'h3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 32-bit ALU between NREQ requesters (e.g. two issue slots, or core plus debug port).
- Each requester issues (x, y, mode) with a valid/ready handshake. The arbiter muxes the winner onto the ALU and registers the result with the requester id.
- Supports a lock so that a MUL/DIV and the following MFHI from the same requester cannot be split by another requester clobbering HI.
- Drives ALU mode 4'b0000 (NOP) whenever nothing is issued.

Parameters:
- N, 32, datapath width.
- NREQ, 2, number of requesters (2..8).
- LOCK_MAX, 8, idle cycles a lock owner may hold the ALU without issuing before forced release.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  per-requester op valid.
- req_x  in  NREQ*N  operand x, requester i at bits [i*N +: N].
- req_y  in  NREQ*N  operand y, same packing.
- req_mode  in  NREQ*4  ALU mode code, requester i at [i*4 +: 4].
- req_lock  in  NREQ  hold the ALU for this requester after this op.
- req_ready  out  NREQ  one-hot grant; the op is accepted when valid & ready.
- alu_x  out  N  to ALU x.
- alu_y  out  N  to ALU y.
- alu_mode  out  4  to ALU mode.
- alu_z  in  N  ALU result, combinational on x/y/mode; HI is updated at the clk edge for MUL/DIV.
- rsp_valid  out  1  result pulse.
- rsp_id  out  $clog2(NREQ)  requester that owns rsp_z.
- rsp_z  out  N  registered result.
- locked  out  1  a lock is currently held.
- lock_timeout  out  1  one-cycle pulse on forced lock release.

Behaviour:
- Reset values:
  - req_ready=0, alu_x=0, alu_y=0, alu_mode=4'b0000.
  - rsp_valid=0, rsp_id=0, rsp_z=0.
  - locked=0, lock_timeout=0, idle counter=0.
  - Round-robin pointer=NREQ-1, so requester 0 has first priority.
- Unlocked cycle:
  - Winner is the first valid requester searching from pointer+1 with wrap-around.
  - req_ready[winner]=1 combinationally; alu_x/y/mode = the winner's fields.
  - The pointer is updated to the winner at the edge.
  - With no valid requester: req_ready=0, alu_mode=0000, alu_x/y=0.
- Latency: an op accepted in cycle t gives rsp_valid=1 in cycle t+1 with rsp_z=alu_z sampled at the t edge and rsp_id=winner. rsp_valid is a 1-cycle pulse. Back-to-back accepts give back-to-back responses (throughput 1/cycle). There is no response backpressure.
- Lock entry: an accepted op with req_lock=1 sets locked=1 with owner=winner at that edge. This applies regardless of mode; the intended use is MUL/DIV followed by MFHI.
- Locked cycle:
  - Only the owner may be granted; other requests see ready=0.
  - An owner op with req_lock=1 keeps the lock.
  - An owner op with req_lock=0 is accepted and releases the lock at that edge.
  - The pointer is set to the owner on release.
- Idle counter: counts locked cycles in which the owner has valid=0, and resets on any owner accept.
  - When it reaches LOCK_MAX, the lock clears at that edge and lock_timeout pulses for 1 cycle.
  - Normal arbitration resumes the next cycle.
- Asynchronous rst mid-operation:
  - Clears lock and counter; any pending response is dropped (rsp_valid=0 immediately).
  - alu_mode is forced to 0000 immediately.
- A requester dropping valid without being accepted is legal; no state changes.

Decomposition:
- Shared package alu_pkg:
  - alu_mode_t (logic [3:0]).
  - Mode constants: ALU_NOP=0000, ADD=0001, SUB=0010, MUL=0011, DIV=0100, AND=0101, OR=0110, XOR=0111, NOR=1000, SLL=1001, SLR=1010, SLT=1011, MFHI=1101, EQ=1110, NEQ=1111.
  - Function writes_hi(mode) returning 1 for MUL/DIV (used by assertions).
- Sub-module rr_arbiter (NREQ, req, ptr, mask -> one-hot grant, index). It is purely combinational; the pointer register lives in alu_arbiter.

Test Plan:
1. Single ADD: req0 ADD, x=0x33333333, y=0x02222222 -> ready0 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_z=0x35555555.
2. Round-robin: req0 and req1 both hold valid with SUB for 4 cycles -> grants 0,1,0,1; responses with ids 0,1,0,1 one cycle later; no bubbles.
3. Locked MUL/MFHI:
   - Stimulus: req0 MUL, x=0x33333333, y=0x02222222, lock=1; next cycle req0 MFHI, lock=0; req1 ADD valid throughout.
   - Required: req1 not granted until the MFHI is accepted; MFHI rsp_z=0x006D3A06; req1 granted the following cycle.
4. Lock timeout (LOCK_MAX=4): req0 MUL with lock=1, then req0 drops valid; req1 valid -> locked=1 for 4 cycles, lock_timeout pulse, req1 granted the next cycle.
5. Reset mid-lock: assert rst while locked with a response pending -> rsp_valid, locked and alu_mode go 0 immediately; after release with req0 and req1 valid, req0 is granted first.
6. Idle: no valid for 10 cycles -> alu_mode=0000 every cycle, rsp_valid never asserts, MFHI afterwards returns the HI from the last real MUL/DIV.
